// File: rtl/sram_like_arbiter_pkg.sv
// sram_like_arbiter_pkg
//   Shared definitions for the SRAM-like arbiter slice:
//   - owner IDs that tag each accepted transaction
//   - SRAM-like field widths
//   - lock FSM state encodings
//   - the request bundle type used by the slave-side mux
package sram_like_arbiter_pkg;

    localparam logic OWN_INST = 1'b0;  // instruction fetch master (m0)
    localparam logic OWN_DATA = 1'b1;  // load/store master (m1)

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 2;
    localparam int STRB_W = 4;

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    typedef struct packed {
        logic              wr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// sram_like_arbiter_owner_fifo
//   Synchronous FIFO of 1-bit owner IDs, one entry per accepted transaction,
//   popped in issue order as responses come back.
// Ports
//   clk, reset   clock, asynchronous active-high reset (empties the FIFO)
//   push, din    enqueue owner ID din (ignored when full)
//   pop          dequeue head (ignored when empty)
//   full, empty  occupancy flags
//   head         owner ID at the front of the queue
module sram_like_arbiter_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like slave port between instruction fetch (m0) and
//   load/store (m1). m1 has fixed priority, but after STARVE_LIMIT
//   consecutive m1 accepts while m0 waits, m0 is granted. Once a request is
//   presented and not accepted, the grant is locked until the address
//   handshake. Accepted transactions are tracked in an owner FIFO so each
//   in-order response is routed back to its issuer.
// Ports
//   clk, reset                      clock, asynchronous active-high reset
//   mX_req/wr/size/wstrb/addr/wdata master request (held until mX_addr_ok)
//   mX_addr_ok                      address handshake to master X
//   mX_data_ok, mX_rdata            response strobe and read data to master X
//   s_req/wr/size/wstrb/addr/wdata  muxed request to the slave
//   s_addr_ok                       slave accepted request
//   s_data_ok, s_rdata              in-order slave response
//
// Lock FSM
//   state       | meaning
//   ST_UNLOCKED | grant recomputed each cycle from priority/starvation rules
//   ST_LOCKED   | request presented but not accepted; grant held at lock_owner
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [SIZE_W-1:0] m0_size,
    input  logic [STRB_W-1:0] m0_wstrb,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_addr_ok,
    output logic              m0_data_ok,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [SIZE_W-1:0] m1_size,
    input  logic [STRB_W-1:0] m1_wstrb,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_addr_ok,
    output logic              m1_data_ok,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_req,
    output logic              s_wr,
    output logic [SIZE_W-1:0] s_size,
    output logic [STRB_W-1:0] s_wstrb,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    input  logic [DATA_W-1:0] s_rdata
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    logic [0:0]     lock_state;
    logic           lock_owner;
    logic [SCW-1:0] starve_cnt;
    logic           grant;
    logic           grant_req;
    logic           accept;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_head;
    sram_req_t      m0_bundle;
    sram_req_t      m1_bundle;
    sram_req_t      sel;

    always_comb begin
        grant = OWN_DATA;
        if (lock_state == ST_LOCKED) begin
            grant = lock_owner;
        end else if (m1_req && (starve_cnt < SCW'(STARVE_LIMIT))) begin
            grant = OWN_DATA;
        end else if (m0_req) begin
            grant = OWN_INST;
        end
    end

    assign m0_bundle = '{wr: m0_wr, size: m0_size, wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
    assign m1_bundle = '{wr: m1_wr, size: m1_size, wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};
    assign sel       = (grant == OWN_DATA) ? m1_bundle : m0_bundle;
    assign grant_req = (grant == OWN_DATA) ? m1_req : m0_req;

    // Full blocks issue even when a pop lands in the same cycle, which keeps
    // s_req free of any combinational path from s_data_ok.
    assign s_req   = grant_req & ~fifo_full;
    assign accept  = s_req & s_addr_ok;

    // Fields are zeroed when idle; while locked s_req stays high so they hold.
    assign s_wr    = s_req & sel.wr;
    assign s_size  = s_req ? sel.size  : '0;
    assign s_wstrb = s_req ? sel.wstrb : '0;
    assign s_addr  = s_req ? sel.addr  : '0;
    assign s_wdata = s_req ? sel.wdata : '0;

    assign m0_addr_ok = accept & (grant == OWN_INST);
    assign m1_addr_ok = accept & (grant == OWN_DATA);

    assign m0_data_ok = s_data_ok & ~fifo_empty & (fifo_head == OWN_INST);
    assign m1_data_ok = s_data_ok & ~fifo_empty & (fifo_head == OWN_DATA);
    assign m0_rdata   = (~fifo_empty && fifo_head == OWN_INST) ? s_rdata : '0;
    assign m1_rdata   = (~fifo_empty && fifo_head == OWN_DATA) ? s_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state <= ST_UNLOCKED;
            lock_owner <= OWN_INST;
        end else begin
            case (lock_state)
                ST_UNLOCKED: begin
                    if (s_req && !s_addr_ok) begin
                        lock_state <= ST_LOCKED;
                        lock_owner <= grant;
                    end
                end
                ST_LOCKED: begin
                    if (s_addr_ok) begin
                        lock_state <= ST_UNLOCKED;
                    end
                end
                default: lock_state <= ST_UNLOCKED;
            endcase
        end
    end

    // Counts consecutive m1 accepts that happened while m0 was waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (grant == OWN_DATA && m0_req) begin
                if (starve_cnt < SCW'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + SCW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    sram_like_arbiter_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .din   (grant),
        .pop   (s_data_ok),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // A response with nothing outstanding is a slave protocol error; it is
    // dropped above and only reported in simulation.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(s_data_ok && fifo_empty))
                else $warning("stray s_data_ok with no outstanding transaction");
        end
    end

endmodule
